shift_sequencer: RTL and testbench



---
 rtl/shift_seq_pkg.sv | 18 +
 rtl/shift_sequencer_shifter.sv | 21 ++
 rtl/shift_sequencer.sv | 79 +++++++
 tb/tb_shift_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and op codes for the shift sequencer and the CPU controller.
package shift_seq_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned AMT_W  = 4;

  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } seq_state_t;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Single-position shifter: pass, logical left, logical right, arithmetic right.
module shifter
  import shift_seq_pkg::*;
(
  input  logic [15:0] in,
  input  logic [1:0]  shift,
  output logic [15:0] sout
);

  // One-bit shift selected by the op code
  always_comb begin
    sout = in;
    case (shift)
      SH_PASS: sout = in;
      SH_LSL:  sout = {in[14:0], 1'b0};
      SH_LSR:  sout = {1'b0, in[15:1]};
      SH_ASR:  sout = {in[15], in[15:1]};
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Variable-amount shift unit: repeats the one-bit shifter `amount` times
// behind a start/done handshake.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned DATA_W = shift_seq_pkg::DATA_W,
  parameter int unsigned AMT_W  = shift_seq_pkg::AMT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        op,
  input  logic [AMT_W-1:0]  amount,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  seq_state_t        state, state_nx;
  logic [DATA_W-1:0] acc, acc_nx;
  logic [1:0]        op_q, op_nx;
  logic [AMT_W-1:0]  cnt, cnt_nx;
  logic [15:0]       sout;

  shifter u_shifter (
    .in    (acc),
    .shift (op_q),
    .sout  (sout)
  );

  // State, accumulator, latched op and step counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      acc   <= '0;
      op_q  <= SH_PASS;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      op_q  <= op_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state: latch on accepted start, one shift step per SHIFT cycle
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    op_nx    = op_q;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          acc_nx   = din;
          op_nx    = op;
          cnt_nx   = amount;
          state_nx = (amount != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        acc_nx = sout;
        cnt_nx = cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state register only
  assign ready  = (state == S_IDLE);
  assign busy   = (state == S_SHIFT);
  assign done   = (state == S_DONE);
  assign result = acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] din;
  logic [1:0]  op;
  logic [3:0]  amount;
  logic        ready, busy, done;
  logic [15:0] result;

  int total = 0;
  int bad   = 0;

  shift_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .din    (din),
    .op     (op),
    .amount (amount),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and run until done (or budget); stops in the done cycle.
  task automatic launch(input logic [15:0] d, input logic [1:0] o, input logic [3:0] a,
                        output int busy_n, output int done_at);
    start = 1'b1; din = d; op = o; amount = a;
    step();
    start = 1'b0; din = 16'hDEAD; op = 2'b00; amount = 4'hF;
    busy_n = 0; done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_n++;
      if (done) begin
        done_at = k;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; din = '0; op = '0; amount = '0;
    step(); step();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h want=0000", result); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_lsl();
    int bn, da;
    launch(16'h0001, SH_LSL, 4'd4, bn, da);
    total++; if (da !== 5) begin bad++; $display("FAIL lsl_latency got=%0d want=5", da); end
    total++; if (bn !== 4) begin bad++; $display("FAIL lsl_busy got=%0d want=4", bn); end
    total++; if (result !== 16'h0010) begin bad++; $display("FAIL lsl_result got=%h want=0010", result); end
    step();
    total++; if (done !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL lsl_pulse done=%b ready=%b want done=0 ready=1", done, ready); end
  endtask

  task automatic test_asr_lsr();
    int bn, da;
    launch(16'h8000, SH_ASR, 4'd15, bn, da);
    total++; if (da !== 16) begin bad++; $display("FAIL asr_latency got=%0d want=16", da); end
    total++; if (bn !== 15) begin bad++; $display("FAIL asr_busy got=%0d want=15", bn); end
    total++; if (result !== 16'hFFFF) begin bad++; $display("FAIL asr_result got=%h want=FFFF", result); end
    step();
    launch(16'h8000, SH_LSR, 4'd15, bn, da);
    total++; if (da !== 16) begin bad++; $display("FAIL lsr_latency got=%0d want=16", da); end
    total++; if (result !== 16'h0001) begin bad++; $display("FAIL lsr_result got=%h want=0001", result); end
    step();
    launch(16'h4321, SH_PASS, 4'd3, bn, da);
    total++; if (da !== 4) begin bad++; $display("FAIL pass_latency got=%0d want=4", da); end
    total++; if (result !== 16'h4321) begin bad++; $display("FAIL pass_result got=%h want=4321", result); end
    step();
  endtask

  task automatic test_zero_amount();
    int bn, da;
    launch(16'hA5A5, SH_LSL, 4'd0, bn, da);
    total++; if (da !== 1) begin bad++; $display("FAIL zero_latency got=%0d want=1", da); end
    total++; if (bn !== 0) begin bad++; $display("FAIL zero_busy got=%0d want=0", bn); end
    total++; if (result !== 16'hA5A5) begin bad++; $display("FAIL zero_result got=%h want=A5A5", result); end
    step();
    total++; if (ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL zero_ready ready=%b done=%b want ready=1 done=0", ready, done); end
  endtask

  task automatic test_back_to_back();
    // accepted request in IDLE, ignored one in DONE, accepted again two cycles later
    start = 1'b1; din = 16'h1111; op = SH_LSL; amount = 4'd0;
    step();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done1 got=%b want=1", done); end
    din = 16'h2222;
    step();
    total++; if (ready !== 1'b1 || result !== 16'h1111) begin bad++; $display("FAIL b2b_ignored ready=%b result=%h want ready=1 result=1111", ready, result); end
    din = 16'h3333;
    step();
    start = 1'b0;
    total++; if (done !== 1'b1 || result !== 16'h3333) begin bad++; $display("FAIL b2b_second done=%b result=%h want done=1 result=3333", done, result); end
    step();
  endtask

  task automatic test_start_while_busy();
    int da, extra;
    start = 1'b1; din = 16'h00F0; op = SH_LSR; amount = 4'd2;
    step();
    din = 16'h1234; op = SH_LSL; amount = 4'd3;
    step();
    start = 1'b0;
    da = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) begin da = 1; break; end
      step();
    end
    total++; if (da !== 1) begin bad++; $display("FAIL busy_start_timeout got=%0d want=1", da); end
    total++; if (result !== 16'h003C) begin bad++; $display("FAIL busy_start_result got=%h want=003C", result); end
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (busy || done) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL busy_start_requeued got=%0d want=0", extra); end
  endtask

  task automatic test_mid_reset();
    int bn, pulses;
    start = 1'b1; din = 16'h0003; op = SH_LSL; amount = 4'd8;
    step();
    start = 1'b0;
    step(); step();
    total++; if (busy !== 1'b1 || result !== 16'h000C) begin bad++; $display("FAIL mreset_pre busy=%b result=%h want busy=1 result=000C", busy, result); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (ready !== 1'b1 || busy !== 1'b0 || result !== 16'h0000 || done !== 1'b0) begin
      bad++; $display("FAIL mreset_state ready=%b busy=%b done=%b result=%h want 1 0 0 0000", ready, busy, done, result);
    end
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL mreset_no_done got=%0d want=0", pulses); end
    // reset together with start drops the request
    reset = 1'b1; start = 1'b1; din = 16'h7777; amount = 4'd0;
    step();
    reset = 1'b0; start = 1'b0;
    step();
    total++; if (ready !== 1'b1 || done !== 1'b0 || result !== 16'h0000) begin
      bad++; $display("FAIL reset_start ready=%b done=%b result=%h want 1 0 0000", ready, done, result);
    end
    bn = 0;
  endtask

  task automatic test_hold();
    int bn, da, changed, pulses;
    launch(16'h0F0F, SH_LSR, 4'd1, bn, da);
    total++; if (result !== 16'h0787) begin bad++; $display("FAIL hold_result got=%h want=0787", result); end
    changed = 0; pulses = 0;
    for (int k = 0; k < 10; k++) begin
      din = 16'(k * 16'h1357);
      step();
      if (result !== 16'h0787) changed++;
      if (done) pulses++;
    end
    total++; if (changed !== 0) begin bad++; $display("FAIL hold_stable got=%0d want=0", changed); end
    total++; if (pulses !== 0) begin bad++; $display("FAIL hold_done got=%0d want=0", pulses); end
  endtask

  initial begin
    test_reset();
    test_lsl();
    test_asr_lsr();
    test_zero_amount();
    test_back_to_back();
    test_start_while_busy();
    test_mid_reset();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
